// File: rtl/noc_vc_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one NoC VC output among PORTS sources.
// Optional per-port completed-packet counters when NOC_ARB_STATS_EN is defined.
module noc_vc_packet_arbiter #(
    parameter int PORTS          = 3,
    parameter int NOC_DATA_WIDTH = 32,
    parameter int NOC_TYPE_WIDTH = 2,
    parameter int STAT_WIDTH     = 16
) (
    input  logic                                               clk,
    input  logic                                               rst_sys_n,
    input  logic [PORTS*(NOC_DATA_WIDTH+NOC_TYPE_WIDTH)-1:0]   in_flit,
    input  logic [PORTS-1:0]                                   in_valid,
    output logic [PORTS-1:0]                                   in_ready,
    output logic [NOC_DATA_WIDTH+NOC_TYPE_WIDTH-1:0]           out_flit,
    output logic                                               out_valid,
    input  logic                                               out_ready,
    output logic [PORTS-1:0]                                   grant,
    output logic                                               busy
`ifdef NOC_ARB_STATS_EN
    ,
    input  logic                                               stat_clear,
    output logic [PORTS*STAT_WIDTH-1:0]                        stat_pkt_count
`endif
);

    localparam int FLIT_WIDTH = NOC_DATA_WIDTH + NOC_TYPE_WIDTH;
    localparam int PTR_W      = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic               sel_found;
    logic [PTR_W-1:0]   sel;
    logic [PTR_W-1:0]   cur;
    logic [PTR_W-1:0]   cur_next;
    logic               active;
    logic               owned;
    logic               handshake;
    logic               end_flit;
    logic [PORTS-1:0]   cur_onehot;
    int unsigned        cand;

    // Round-robin search starting at rr_ptr, wrapping modulo PORTS.
    always_comb begin
        sel_found = 1'b0;
        sel       = '0;
        cand      = 0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            cand = 32'(rr_ptr_q) + i;
            if (cand >= PORTS) begin
                cand = cand - PORTS;
            end
            if (!sel_found && in_valid[cand]) begin
                sel_found = 1'b1;
                sel       = PTR_W'(cand);
            end
        end
    end

    always_comb begin
        cur        = (state_q == LOCKED) ? owner_q : sel;
        owned      = (state_q == LOCKED) || sel_found;
        active     = (state_q == LOCKED) ? in_valid[owner_q] : sel_found;
        cur_next   = (32'(cur) == PORTS - 1) ? '0 : cur + 1'b1;
        cur_onehot = '0;
        cur_onehot[cur] = 1'b1;

        out_flit   = in_flit[int'(cur)*FLIT_WIDTH +: FLIT_WIDTH];
        end_flit   = out_flit[FLIT_WIDTH-1];
        out_valid  = active && rst_sys_n;
        in_ready   = (owned && rst_sys_n) ? (cur_onehot & {PORTS{out_ready}}) : '0;
        grant      = (owned && rst_sys_n) ? cur_onehot : '0;
        busy       = (state_q == LOCKED) && rst_sys_n;
        handshake  = out_valid && out_ready;
    end

    // A backpressured first flit still locks the owner so out_flit cannot switch.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    if (handshake && end_flit) begin
                        rr_ptr_d = cur_next;
                    end else begin
                        state_d = LOCKED;
                        owner_d = sel;
                    end
                end
            end
            LOCKED: begin
                if (handshake && end_flit) begin
                    state_d  = IDLE;
                    rr_ptr_d = cur_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef NOC_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] cnt_q [PORTS];
    logic [STAT_WIDTH-1:0] cnt_d [PORTS];

    // Clear wins over a same-cycle increment; counters saturate at all-ones.
    always_comb begin
        stat_pkt_count = '0;
        for (int unsigned p = 0; p < PORTS; p++) begin
            cnt_d[p] = cnt_q[p];
            if (stat_clear) begin
                cnt_d[p] = '0;
            end else if (handshake && end_flit && (cur == PTR_W'(p)) && (cnt_q[p] != '1)) begin
                cnt_d[p] = cnt_q[p] + 1'b1;
            end
            stat_pkt_count[p*STAT_WIDTH +: STAT_WIDTH] = cnt_q[p];
        end
    end

    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            for (int unsigned p = 0; p < PORTS; p++) begin
                cnt_q[p] <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < PORTS; p++) begin
                cnt_q[p] <= cnt_d[p];
            end
        end
    end
`endif

endmodule
